ring_slot_monitor: RTL and testbench
====================================

RING_SLOT_MONITOR -- requirements
Module: ring_slot_monitor

Interface
REQ-001 Parameter REV_W, default 16, sets the width of the revolution counter.
REQ-002 Parameter ERR_W, default 8, sets the width of the error counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  sample enable; count_in is sampled only on edges where en=1.
REQ-006 count_in  input  8  one-hot ring-counter phase from the upstream 8-bit ring counter (rotates left, bit7 wraps to bit0).
REQ-007 clear_err  input  1  synchronous clear of err_sticky and err_cnt.
REQ-008 slot_idx  output  3  binary index of the set bit of the last accepted sample.
REQ-009 slot_valid  output  1  slot_idx holds a valid one-hot decode.
REQ-010 locked  output  1  monitor is in state LOCKED.
REQ-011 rev_cnt  output  REV_W  count of completed revolutions while locked.
REQ-012 rev_pulse  output  1  one-cycle strobe per completed revolution.
REQ-013 err_sticky  output  1  a rotation error has occurred since reset or clear.
REQ-014 err_cnt  output  ERR_W  number of rotation errors; saturates.

Function
REQ-015 All outputs SHALL be registered; the response to a sample SHALL be visible one edge after the sample (latency 1).
REQ-016 A sample SHALL be one-hot iff exactly one bit of count_in is 1; expected(prev) SHALL be {prev[6:0], prev[7]}.
REQ-017 Internal state: FSM {SYNC, LOCKED}, an 8-bit prev register, and a prev_ok flag.
REQ-018 en=0: all registers SHALL hold, except rev_pulse, which SHALL be 0.
REQ-019 SYNC, sample not one-hot: prev_ok=0 and slot_valid=0; stay in SYNC; no error is counted.
REQ-020 SYNC, sample one-hot: prev=sample, prev_ok=1, slot_idx=index, and slot_valid=1.
REQ-021 SYNC to LOCKED when prev_ok=1 and the sample equals expected(prev); locked=1 from the next edge.
REQ-022 SYNC, one-hot sample that does not equal expected(prev): resynchronise on the new sample; no error is counted.
REQ-023 LOCKED, sample equals expected(prev): update prev, slot_idx and slot_valid=1; remain in LOCKED.
REQ-024 LOCKED, sample = 8'h01 (bit7 wrapped to bit0): rev_cnt increments modulo 2^REV_W, and rev_pulse=1 for exactly one cycle.
REQ-025 rev_cnt SHALL wrap from all-ones to 0 and still assert rev_pulse.
REQ-026 LOCKED, sample not equal to expected(prev), including non-one-hot values, 8'h00, or a stall repeating the same value:
- err_sticky=1
- err_cnt increments, saturating at all-ones
- state returns to SYNC
- locked=0, slot_valid=0, prev_ok=0
- rev_cnt holds
REQ-027 clear_err=1 with no error on the same edge: err_sticky=0 and err_cnt=0.
REQ-028 clear_err=1 on the same edge as an error: the error SHALL win, giving err_sticky=1 and err_cnt=1.
REQ-029 clear_err SHALL act regardless of en.
REQ-030 rev_cnt is never cleared except by reset.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force the following values:
- state=SYNC, prev=0, prev_ok=0
- slot_idx=0, slot_valid=0, locked=0
- rev_cnt=0, rev_pulse=0
- err_sticky=0, err_cnt=0
REQ-032 An rst_n assertion mid-revolution SHALL discard all lock and count state; after release the monitor SHALL relock via REQ-020 and REQ-021.
REQ-033 rst_n deassertion SHALL be synchronised by the integrator; the block SHALL take no action on the release edge other than normal sampling.

Verification
REQ-034 Lock and decode: en=1, count_in 8'h80 then 8'h01 then 8'h02 -> slot_idx 7, 0, 1; locked=1 after the second sample; rev_pulse=1 on the cycle after 8'h01 only if already locked, so no pulse in this case.
REQ-035 Revolution counting: locked, drive 3 full rotations 8'h01..8'h80 -> rev_cnt=3 and three single-cycle rev_pulse strobes, each following the edge that sampled 8'h01.
REQ-036 Error detection: locked at 8'h04, drive 8'h10 -> err_sticky=1, err_cnt=1, locked=0, slot_valid=0; then 8'h20, 8'h40 -> relocked, err_cnt still 1.
REQ-037 Saturation and clear: inject 300 errors with ERR_W=8 -> err_cnt=255; clear_err=1 -> 0; clear_err coincident with an error -> err_cnt=1, err_sticky=1.
REQ-038 Enable stall: locked at 8'h08, en=0 for 5 cycles while count_in changes -> all outputs hold and rev_pulse=0; en=1 with 8'h10 -> no error.
REQ-039 Async reset: rev_cnt=5 and locked, assert rst_n between edges -> all outputs 0 before the next clk edge; release and drive 8'h40, 8'h80 -> locked=1, rev_cnt=0.

Source files
------------

// File: rtl/ring_slot_monitor.sv
// ring_slot_monitor
// Watches the phase of an upstream 8-bit one-hot ring counter that rotates left.
// It locks onto a correctly rotating sequence and decodes the active slot.
// It counts completed revolutions and detects rotation faults (skips, stalls,
// corrupted or empty patterns). Every output is registered.

module ring_slot_monitor #(
    parameter int REV_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       count_in,
    input  logic             clear_err,
    output logic [2:0]       slot_idx,
    output logic             slot_valid,
    output logic             locked,
    output logic [REV_W-1:0] rev_cnt,
    output logic             rev_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] prev;
    logic       prev_ok;

    logic [3:0] ones;
    logic       one_hot;
    logic [2:0] sample_idx;
    logic [7:0] expected;
    logic       match;
    logic       rot_err;

    // Classify the current sample: population count, binary index, and whether
    // it is the next phase after the last accepted one.
    always_comb begin
        ones       = 4'd0;
        sample_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'd0, count_in[i]};
            if (count_in[i]) begin
                sample_idx = sample_idx | 3'(i);
            end
        end
        one_hot  = (ones == 4'd1);
        expected = {prev[6:0], prev[7]};
        match    = (count_in == expected);
        rot_err  = en && (state == LOCKED) && !match;
    end

    // Lock FSM, slot decode, revolution counting and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            prev       <= 8'd0;
            prev_ok    <= 1'b0;
            slot_idx   <= 3'd0;
            slot_valid <= 1'b0;
            locked     <= 1'b0;
            rev_cnt    <= '0;
            rev_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            // The strobe is only ever high for the cycle after a wrap.
            rev_pulse <= 1'b0;

            if (en) begin
                if (state == SYNC) begin
                    if (!one_hot) begin
                        // Garbage while hunting: forget the reference, no error.
                        prev_ok    <= 1'b0;
                        slot_valid <= 1'b0;
                    end else begin
                        // Two consecutive correct phases are needed to lock;
                        // any other one-hot value simply becomes the new reference.
                        if (prev_ok && match) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                        prev       <= count_in;
                        prev_ok    <= 1'b1;
                        slot_idx   <= sample_idx;
                        slot_valid <= 1'b1;
                    end
                end else begin
                    if (match) begin
                        prev       <= count_in;
                        slot_idx   <= sample_idx;
                        slot_valid <= 1'b1;
                        // Bit 7 wrapping back to bit 0 closes one revolution.
                        if (count_in == 8'h01) begin
                            rev_cnt   <= rev_cnt + 1'b1;
                            rev_pulse <= 1'b1;
                        end
                    end else begin
                        // Lost rotation: drop lock and start hunting afresh.
                        state      <= SYNC;
                        locked     <= 1'b0;
                        slot_valid <= 1'b0;
                        prev_ok    <= 1'b0;
                    end
                end
            end

            // An error on the same edge as a clear wins and counts as the first one.
            if (rot_err) begin
                err_sticky <= 1'b1;
                if (clear_err) begin
                    err_cnt <= {{(ERR_W-1){1'b0}}, 1'b1};
                end else if (!(&err_cnt)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (clear_err) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ring_slot_monitor.sv
// Scoreboard bench for ring_slot_monitor. A behavioural reference model
// predicts the outputs for each driven sample. The prediction is queued and
// then compared one edge later against the outputs of the design.

module tb_ring_slot_monitor;

    localparam int REV_W = 4;
    localparam int ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [7:0]       count_in;
    logic             clear_err;
    logic [2:0]       slot_idx;
    logic             slot_valid;
    logic             locked;
    logic [REV_W-1:0] rev_cnt;
    logic             rev_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;

    ring_slot_monitor #(.REV_W(REV_W), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count_in   (count_in),
        .clear_err  (clear_err),
        .slot_idx   (slot_idx),
        .slot_valid (slot_valid),
        .locked     (locked),
        .rev_cnt    (rev_cnt),
        .rev_pulse  (rev_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       idx;
        logic             valid;
        logic             lock;
        logic [REV_W-1:0] rev;
        logic             pulse;
        logic             sticky;
        logic [ERR_W-1:0] errc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int txn      = 0;
    int pulses   = 0;

    // Reference model state
    logic             m_lock;
    logic [7:0]       m_prev;
    logic             m_prev_ok;
    logic [2:0]       m_idx;
    logic             m_valid;
    logic [REV_W-1:0] m_rev;
    logic             m_pulse;
    logic             m_sticky;
    logic [ERR_W-1:0] m_errc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (txn %0d)", tag, obs, exp_v, txn);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_prev = 0; m_prev_ok = 0; m_idx = 0; m_valid = 0;
        m_rev = 0; m_pulse = 0; m_sticky = 0; m_errc = 0;
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.idx = m_idx; e.valid = m_valid; e.lock = m_lock; e.rev = m_rev;
        e.pulse = m_pulse; e.sticky = m_sticky; e.errc = m_errc;
        return e;
    endfunction

    // Behavioural prediction of the outputs after one edge.
    task automatic model_step(input logic e, input logic [7:0] s, input logic clr);
        logic       err;
        logic       oh;
        logic [7:0] nxt;
        err     = 1'b0;
        m_pulse = 1'b0;
        if (e) begin
            oh  = (s != 8'd0) && ((s & (s - 8'd1)) == 8'd0);
            nxt = {m_prev[6:0], m_prev[7]};
            if (!m_lock) begin
                if (!oh) begin
                    m_prev_ok = 1'b0;
                    m_valid   = 1'b0;
                end else begin
                    if (m_prev_ok && s == nxt) m_lock = 1'b1;
                    m_prev    = s;
                    m_prev_ok = 1'b1;
                    m_idx     = 3'($clog2(s));
                    m_valid   = 1'b1;
                end
            end else if (s == nxt) begin
                m_prev  = s;
                m_idx   = 3'($clog2(s));
                m_valid = 1'b1;
                if (s == 8'h01) begin
                    m_rev   = m_rev + 1'b1;
                    m_pulse = 1'b1;
                end
            end else begin
                err       = 1'b1;
                m_lock    = 1'b0;
                m_valid   = 1'b0;
                m_prev_ok = 1'b0;
            end
        end
        if (err) begin
            m_sticky = 1'b1;
            if (clr)                  m_errc = 8'd1;
            else if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        end else if (clr) begin
            m_sticky = 1'b0;
            m_errc   = 8'd0;
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        $display("txn %0d en=%b in=%h clr=%b -> idx=%0d valid=%b locked=%b rev=%0d pulse=%b sticky=%b errc=%0d",
                 txn, en, count_in, clear_err, slot_idx, slot_valid, locked, rev_cnt,
                 rev_pulse, err_sticky, err_cnt);
        check("slot_idx",   32'(slot_idx),   32'(e.idx));
        check("slot_valid", 32'(slot_valid), 32'(e.valid));
        check("locked",     32'(locked),     32'(e.lock));
        check("rev_cnt",    32'(rev_cnt),    32'(e.rev));
        check("rev_pulse",  32'(rev_pulse),  32'(e.pulse));
        check("err_sticky", 32'(err_sticky), 32'(e.sticky));
        check("err_cnt",    32'(err_cnt),    32'(e.errc));
        if (rev_pulse) pulses++;
        txn++;
    endtask

    task automatic step(input logic e, input logic [7:0] s, input logic clr);
        @(negedge clk);
        en        = e;
        count_in  = s;
        clear_err = clr;
        model_step(e, s, clr);
        exp_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic rotate(input int n);
        logic [7:0] s;
        for (int r = 0; r < n; r++) begin
            s = 8'h01;
            for (int b = 0; b < 8; b++) begin
                step(1'b1, s, 1'b0);
                s = {s[6:0], s[7]};
            end
        end
    endtask

    initial begin
        logic [REV_W-1:0] rev_before;
        rst_n     = 1'b0;
        en        = 1'b0;
        count_in  = 8'd0;
        clear_err = 1'b0;
        model_reset();
        #2;
        exp_q.push_back(model_snapshot());
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Lock and decode: 80, 01, 02
        step(1, 8'h80, 0);
        check("lock_idx7", 32'(slot_idx), 32'd7);
        step(1, 8'h01, 0);
        check("lock_after2", 32'(locked), 32'd1);
        check("no_pulse_on_lock", 32'(rev_pulse), 32'd0);
        step(1, 8'h02, 0);
        check("lock_idx1", 32'(slot_idx), 32'd1);

        // Finish this revolution, then three full rotations
        for (int b = 2; b < 8; b++) step(1, 8'h01 << b, 0);
        pulses = 0;
        rotate(3);
        check("rev_after_3", 32'(rev_cnt), 32'd3);
        check("pulses_3", 32'(pulses), 32'd3);

        // Error detection: locked at 04, skip to 10, then relock on 20, 40
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h04, 0);
        step(1, 8'h10, 0);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        check("err_unlocked", 32'(locked), 32'd0);
        step(1, 8'h20, 0);
        step(1, 8'h40, 0);
        check("relocked", 32'(locked), 32'd1);
        check("err_still_1", 32'(err_cnt), 32'd1);

        // Enable stall: locked at 08, en=0 for 5 cycles with changing input
        step(1, 8'h80, 0);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h04, 0);
        step(1, 8'h08, 0);
        for (int i = 0; i < 5; i++) step(0, 8'($urandom), 0);
        step(1, 8'h10, 0);
        check("stall_no_err", 32'(err_cnt), 32'd1);

        // Saturation: 300 more errors (stall on a repeated value and empty pattern)
        for (int i = 0; i < 300; i++) begin
            step(1, (i % 2 == 0) ? 8'h00 : 8'h10, 0);
            step(1, 8'h01, 0);
            step(1, 8'h02, 0);
            step(1, 8'h04, 0);
            step(1, 8'h08, 0);
            step(1, 8'h10, 0);
        end
        check("err_sat", 32'(err_cnt), 32'd255);
        step(0, 8'h55, 1);
        check("clear_no_en", 32'(err_cnt), 32'd0);
        check("clear_sticky", 32'(err_sticky), 32'd0);
        step(1, 8'h00, 1);
        check("clear_vs_err", 32'(err_cnt), 32'd1);
        check("clear_vs_err_sticky", 32'(err_sticky), 32'd1);

        // Revolution counter wrap (REV_W=4): sixteen revolutions return to start
        step(1, 8'h40, 0);
        step(1, 8'h80, 0);
        rev_before = rev_cnt;
        pulses = 0;
        rotate(16);
        check("rev_wrap", 32'(rev_cnt), 32'(rev_before));
        check("wrap_pulses", 32'(pulses), 32'd16);

        // Asynchronous reset mid-revolution, between edges
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_snapshot());
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h40, 0);
        step(1, 8'h80, 0);
        check("post_rst_locked", 32'(locked), 32'd1);
        check("post_rst_rev", 32'(rev_cnt), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
